// File: rtl/out7seg_scan.sv
// out7seg_scan -- time-multiplexed common-anode 7-segment display scanner.
//
// Scans NUM_DIGITS digits round-robin over one shared segment bus. Each digit
// slot lasts CLK_DIV cycles; its first DEAD_CYCLES cycles keep every digit
// disabled so the previous digit's pattern does not ghost onto the next.
// Character codes, decimal points and blank flags live in shadow registers
// that are loaded by a one-cycle strobe.
//
// Optional feature macro: OUT7SEG_BLINK_EN
//   Adds the blink_mask port, a frame counter and a blink phase bit. While the
//   phase is 1, masked digits have their segments forced dark.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   load         one-cycle strobe capturing chars/dp/blank(/blink_mask)
//   chars        5-bit character code per digit, digit i at [5i+4:5i]
//   dp           decimal point per digit, 1 = lit
//   blank        per-digit blank, 1 = digit dark
//   blink_mask   digits that blink (OUT7SEG_BLINK_EN only)
//   segs         active-low segments, [6:0] = a..g, [7] = dp
//   digit_en_n   active-low digit enables, at most one low
//   frame_tick   one-cycle pulse after each complete scan
module out7seg_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int DEAD_CYCLES  = 500,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [5*NUM_DIGITS-1:0] chars,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
`ifdef OUT7SEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic [7:0]              segs,
  output logic [NUM_DIGITS-1:0]   digit_en_n,
  output logic                    frame_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // Character generator, gfedcba active-high. Codes 23..31 are dark.
  function automatic logic [6:0] pat(input logic [4:0] code);
    case (code)
      5'd0:  pat = 7'h3F;
      5'd1:  pat = 7'h06;
      5'd2:  pat = 7'h5B;
      5'd3:  pat = 7'h4F;
      5'd4:  pat = 7'h66;
      5'd5:  pat = 7'h6D;
      5'd6:  pat = 7'h7D;
      5'd7:  pat = 7'h07;
      5'd8:  pat = 7'h7F;
      5'd9:  pat = 7'h6F;
      5'd10: pat = 7'h77;
      5'd11: pat = 7'h7C;
      5'd12: pat = 7'h39;
      5'd13: pat = 7'h5E;
      5'd14: pat = 7'h79;
      5'd15: pat = 7'h71;
      5'd16: pat = 7'h40;
      5'd17: pat = 7'h50;
      5'd18: pat = 7'h5C;
      5'd19: pat = 7'h54;
      5'd20: pat = 7'h73;
      5'd21: pat = 7'h38;
      5'd22: pat = 7'h76;
      default: pat = 7'h00;
    endcase
  endfunction

  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [IW-1:0]                 idx_q, idx_d;
  logic [NUM_DIGITS-1:0][4:0]    chars_sh_q, chars_sh_d;
  logic [NUM_DIGITS-1:0]         dp_sh_q, dp_sh_d;
  logic [NUM_DIGITS-1:0]         blank_sh_q, blank_sh_d;
  logic [7:0]                    segs_q, segs_d;
  logic [NUM_DIGITS-1:0]         en_n_q, en_n_d;
  logic                          frame_tick_q, frame_tick_d;
  logic                          cnt_wrap, idx_last, frame_end, dark;

`ifdef OUT7SEG_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [NUM_DIGITS-1:0] blink_sh_q, blink_sh_d;
  logic [FW-1:0]         frame_cnt_q, frame_cnt_d;
  logic                  phase_q, phase_d;
`endif

  assign cnt_wrap  = (cnt_q == CW'(CLK_DIV - 1));
  assign idx_last  = (idx_q == IW'(NUM_DIGITS - 1));
  // The last cycle of the last slot: idx wraps to 0 on this edge.
  assign frame_end = cnt_wrap && idx_last;

  always_comb begin
    cnt_d        = cnt_wrap ? '0 : cnt_q + CW'(1);
    idx_d        = idx_q;
    if (cnt_wrap) idx_d = idx_last ? '0 : idx_q + IW'(1);
    frame_tick_d = frame_end;

    chars_sh_d = load ? chars : chars_sh_q;
    dp_sh_d    = load ? dp    : dp_sh_q;
    blank_sh_d = load ? blank : blank_sh_q;

    dark = blank_sh_q[idx_q];
`ifdef OUT7SEG_BLINK_EN
    blink_sh_d  = load ? blink_mask : blink_sh_q;
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    // Phase flips on the frame boundary itself so a whole frame sees one phase.
    if (frame_end) begin
      if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end
    dark = dark || (phase_q && blink_sh_q[idx_q]);
`endif

    // Output stage: one cycle behind (cnt, idx); shadow is read as currently held.
    if (cnt_q < CW'(DEAD_CYCLES)) begin
      en_n_d = '1;
      segs_d = 8'hFF;
    end else begin
      en_n_d = ~(NUM_DIGITS'(1) << idx_q);
      segs_d = dark ? 8'hFF : ~{dp_sh_q[idx_q], pat(chars_sh_q[idx_q])};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      chars_sh_q   <= {NUM_DIGITS{5'd31}};
      dp_sh_q      <= '0;
      blank_sh_q   <= '1;
      segs_q       <= 8'hFF;
      en_n_q       <= '1;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      chars_sh_q   <= chars_sh_d;
      dp_sh_q      <= dp_sh_d;
      blank_sh_q   <= blank_sh_d;
      segs_q       <= segs_d;
      en_n_q       <= en_n_d;
      frame_tick_q <= frame_tick_d;
    end
  end

`ifdef OUT7SEG_BLINK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_sh_q  <= '0;
      frame_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_sh_q  <= blink_sh_d;
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
    end
  end
`endif

  assign segs       = segs_q;
  assign digit_en_n = en_n_q;
  assign frame_tick = frame_tick_q;

endmodule
